// File: rtl/alu_pkg.sv
// Shared definitions for the command sequencer and its sibling ALU.
// Holds the opcode encoding (used by both blocks) and the sequencer's
// FSM state encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_NOTA = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU, instantiated beside alu_cmd_seq in the parent.
// Ports:
//   a, b    : OP_W-bit operands
//   sel     : opcode (alu_pkg OP_*)
//   result  : 2*OP_W-bit result; logic ops fill only the low OP_W bits,
//             SUB wraps modulo 2^(2*OP_W).
module alu
    import alu_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    input  logic [2:0]        sel,
    output logic [2*OP_W-1:0] result
);

    logic [2*OP_W-1:0] w_a;
    logic [2*OP_W-1:0] w_b;

    assign w_a = {{OP_W{1'b0}}, a};
    assign w_b = {{OP_W{1'b0}}, b};

    always_comb begin
        result = '0;
        case (sel)
            OP_ADD:  result = w_a + w_b;
            OP_SUB:  result = w_a - w_b;
            OP_MUL:  result = w_a * w_b;
            OP_AND:  result = w_a & w_b;
            OP_OR:   result = w_a | w_b;
            OP_NOTA: result = {{OP_W{1'b0}}, ~a};
            OP_XOR:  result = w_a ^ w_b;
            OP_XNOR: result = {{OP_W{1'b0}}, ~(a ^ b)};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// Command sequencer in front of a combinational ALU.
// Accepts one command (a, b, sel) over a valid/ready handshake, drives it
// to the ALU on registered alu_* outputs, captures the ALU result one
// cycle later and holds it on out_* until downstream takes it.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   in_valid/in_ready          : command handshake; in_a, in_b, in_sel
//   alu_a/alu_b/alu_sel        : registered operands to the ALU
//   alu_result                 : combinational result from the ALU
//   out_valid/out_ready        : result handshake; out_result/sel/zero
//   op_count                   : completed output handshakes (wraps)
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int OP_W  = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic [2:0]        in_sel,
    output logic [OP_W-1:0]   alu_a,
    output logic [OP_W-1:0]   alu_b,
    output logic [2:0]        alu_sel,
    input  logic [2*OP_W-1:0] alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*OP_W-1:0] out_result,
    output logic [2:0]        out_sel,
    output logic              out_zero,
    output logic [CNT_W-1:0]  op_count
);

    seq_state_t        r_state;
    seq_state_t        w_next;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_capture;

    logic [OP_W-1:0]   r_alu_a;
    logic [OP_W-1:0]   r_alu_b;
    logic [2:0]        r_alu_sel;
    logic [2*OP_W-1:0] r_out_result;
    logic [2:0]        r_out_sel;
    logic              r_out_zero;
    logic [CNT_W-1:0]  r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // In HOLD, ready follows out_ready so a new command can enter on the
    // same edge the current result leaves.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_next = ST_EXEC;
            end
            ST_EXEC: begin
                w_capture = 1'b1;
                w_next    = ST_HOLD;
            end
            ST_HOLD: begin
                w_out_valid = 1'b1;
                w_in_ready  = out_ready;
                if (out_ready) w_next = in_valid ? ST_EXEC : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = w_out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= '0;
            r_out_result <= '0;
            r_out_sel    <= '0;
            r_out_zero   <= 1'b0;
            r_op_count   <= '0;
        end else begin
            if (w_in_fire) begin
                r_alu_a   <= in_a;
                r_alu_b   <= in_b;
                r_alu_sel <= in_sel;
            end
            if (w_capture) begin
                r_out_result <= alu_result;
                r_out_sel    <= r_alu_sel;
                r_out_zero   <= (alu_result == '0);
            end
            if (w_out_fire) r_op_count <= r_op_count + 1'b1;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign out_result = r_out_result;
    assign out_sel    = r_out_sel;
    assign out_zero   = r_out_zero;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq with its sibling ALU. Expected results are pushed
// when a command is accepted and popped when the output handshake fires.
module tb_alu_cmd_seq;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_sel;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_result;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [2:0] out_sel;
    logic       out_zero;
    logic [7:0] op_count;

    int         total;
    int         bad;
    logic [7:0] exp_cnt;
    logic [11:0] exp_q[$];
    logic [11:0] mon_e;

    alu_cmd_seq #(.OP_W(4), .CNT_W(8)) u_seq (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_sel(out_sel), .out_zero(out_zero),
        .op_count(op_count)
    );

    alu #(.OP_W(4)) u_alu (
        .a(alu_a), .b(alu_b), .sel(alu_sel), .result(alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [2:0] s, input int a, input int b);
        int r;
        case (s)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a * b;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = (~a) & 15;
            3'd6: r = a ^ b;
            default: r = (~(a ^ b)) & 15;
        endcase
        return r[7:0];
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] r;
        bit ok;
        ok = 0;
        in_sel = s; in_a = a; in_b = b; in_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                r = model(s, int'(a), int'(b));
                exp_q.push_back({(r == 8'd0), s, r});
                ok = 1;
            end
        end
        if (!ok) chk("issue_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) ok = 1;
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    // Scoreboard and counter model, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("op_count", op_count, exp_cnt);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_result", out_result, mon_e[7:0]);
                    chk("out_sel", out_sel, mon_e[10:8]);
                    chk("out_zero", out_zero, mon_e[11]);
                end
                exp_cnt <= exp_cnt + 8'd1;
            end
        end
    end

    initial begin
        total = 0; bad = 0; exp_cnt = 8'd0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sel = '0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_out_result", out_result, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single ADD with latency check.
        out_ready = 1'b1;
        issue(OP_ADD, 4'd3, 4'd2);
        chk("add_lat_vld0", out_valid, 0);
        chk("add_exec_rdy", in_ready, 0);
        @(posedge clk); #1;
        chk("add_lat_vld1", out_valid, 1);
        chk("add_result", out_result, 5);
        chk("add_sel", out_sel, OP_ADD);
        wait_idle();
        chk("add_count", op_count, 1);

        // MUL stalled downstream, AND waiting upstream.
        out_ready = 1'b0;
        issue(OP_MUL, 4'd3, 4'd2);
        in_valid = 1'b1; in_a = 4'd3; in_b = 4'd2; in_sel = OP_AND;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_result", out_result, 6);
            chk("stall_valid", out_valid, 1);
            chk("stall_rdy", in_ready, 0);
            chk("stall_alu_sel", alu_sel, OP_MUL);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(OP_AND, 4'd3, 4'd2);
        chk("same_edge_count", op_count, 2);
        chk("same_edge_alu_sel", alu_sel, OP_AND);
        chk("same_edge_vld", out_valid, 0);
        @(posedge clk); #1;
        chk("and_result", out_result, 2);
        chk("and_zero", out_zero, 0);
        wait_idle();

        // Zero flag.
        issue(OP_SUB, 4'd2, 4'd2);
        @(posedge clk); #1;
        chk("sub_result", out_result, 0);
        chk("sub_zero", out_zero, 1);
        wait_idle();

        // in_valid pulsed during EXEC is ignored.
        issue(OP_XOR, 4'd5, 4'd3);
        in_valid = 1'b1; in_a = 4'd9; in_b = 4'd7; in_sel = OP_OR;
        @(negedge clk);
        chk("ign_rdy", in_ready, 0);
        chk("ign_alu_a", alu_a, 5);
        chk("ign_alu_b", alu_b, 3);
        chk("ign_alu_sel", alu_sel, OP_XOR);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("ign_alu_a2", alu_a, 5);
        chk("ign_alu_sel2", alu_sel, OP_XOR);
        wait_idle();
        repeat (4) @(negedge clk);
        chk("ign_no_extra", out_valid, 0);
        chk("ign_q_empty", exp_q.size(), 0);
        @(posedge clk); #1;

        // Reset in the middle of HOLD.
        out_ready = 1'b0;
        issue(OP_NOTA, 4'd1, 4'd1);
        @(posedge clk); #3;
        chk("hold_pre_rst", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_op_count", op_count, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_out_result", out_result, 0);
        chk("mrst_alu_sel", alu_sel, 0);
        exp_q.delete();
        exp_cnt = 8'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // 256 completions wrap the counter back to zero.
        for (int i = 0; i < 256; i++)
            issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        wait_idle();
        chk("wrap_count", op_count, 0);
        chk("wrap_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
